// File: rtl/axil_master_wrapper_pkg.sv
// Shared definitions for the AXI4-Lite master bridge:
// response codes, FSM state encodings and default bus widths.
package axil_master_wrapper_pkg;

  localparam int AXI_DATA_WIDTH_DEF = 32;
  localparam int AXI_ADDR_WIDTH_DEF = 32;

  localparam logic [1:0] AXI_OKAY   = 2'd0;
  localparam logic [1:0] AXI_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_SLVERR = 2'd2;
  localparam logic [1:0] AXI_DECERR = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axil_master_core.sv
// Independent write and read FSMs turning single-beat user requests into AXI4-Lite
// transactions; one request in flight per direction, done pulses one cycle after B/R handshake.
module axil_master_core
  import axil_master_wrapper_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  output logic                        wr_done,
  output logic [1:0]                  wr_error,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_done,
  output logic [1:0]                  rd_error,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_state_t wr_state;
  rd_state_t rd_state;
  wr_req_t   wr_req;
  logic      aw_hs;
  logic      w_hs;
  logic      aw_clear;
  logic      w_clear;

  assign m_axil_awaddr = wr_req.addr;
  assign m_axil_wdata  = wr_req.data;
  assign m_axil_wstrb  = '1;

  // A channel is clear once its valid is low (handshake already taken) or handshakes now.
  assign aw_hs    = m_axil_awvalid && m_axil_awready;
  assign w_hs     = m_axil_wvalid && m_axil_wready;
  assign aw_clear = aw_hs || !m_axil_awvalid;
  assign w_clear  = w_hs || !m_axil_wvalid;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state       <= W_IDLE;
      wr_ready       <= 1'b1;
      wr_done        <= 1'b0;
      wr_error       <= AXI_OKAY;
      wr_req         <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      unique case (wr_state)
        W_IDLE: begin
          if (wr_valid) begin
            wr_req.addr    <= wr_addr;
            wr_req.data    <= wr_data;
            m_axil_awvalid <= 1'b1;
            m_axil_wvalid  <= 1'b1;
            wr_ready       <= 1'b0;
            wr_state       <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_hs) m_axil_awvalid <= 1'b0;
          if (w_hs)  m_axil_wvalid  <= 1'b0;
          if (aw_clear && w_clear) begin
            m_axil_bready <= 1'b1;
            wr_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            wr_error      <= m_axil_bresp;
            wr_done       <= 1'b1;
            wr_ready      <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: begin
          m_axil_awvalid <= 1'b0;
          m_axil_wvalid  <= 1'b0;
          m_axil_bready  <= 1'b0;
          wr_ready       <= 1'b1;
          wr_state       <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state       <= R_IDLE;
      rd_ready       <= 1'b1;
      rd_done        <= 1'b0;
      rd_error       <= AXI_OKAY;
      rd_data        <= '0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      unique case (rd_state)
        R_IDLE: begin
          if (rd_valid) begin
            m_axil_araddr  <= rd_addr;
            m_axil_arvalid <= 1'b1;
            rd_ready       <= 1'b0;
            rd_state       <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            rd_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rd_data       <= m_axil_rdata;
            rd_error      <= m_axil_rresp;
            rd_done       <= 1'b1;
            rd_ready      <= 1'b1;
            rd_state      <= R_IDLE;
          end
        end
        default: begin
          m_axil_arvalid <= 1'b0;
          m_axil_rready  <= 1'b0;
          rd_ready       <= 1'b1;
          rd_state       <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/axil_master_wrapper.sv
// AXI4-Lite master bridge top: maps parameters and ports onto axil_master_core.
// Latency and backpressure follow the core: one request per direction in flight, waits indefinitely on the slave.
module axil_master_wrapper
  import axil_master_wrapper_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
  output logic                        wr_done,
  output logic [1:0]                  wr_error,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_done,
  output logic [1:0]                  rd_error,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                        m_axil_awvalid,
  input  logic                        m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                        m_axil_wvalid,
  input  logic                        m_axil_wready,
  input  logic [1:0]                  m_axil_bresp,
  input  logic                        m_axil_bvalid,
  output logic                        m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                        m_axil_arvalid,
  input  logic                        m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                  m_axil_rresp,
  input  logic                        m_axil_rvalid,
  output logic                        m_axil_rready
);

  axil_master_core #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_core (
    .aclk           (aclk),
    .areset         (areset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_done        (wr_done),
    .wr_error       (wr_error),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_done        (rd_done),
    .rd_error       (rd_error),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

endmodule

// File: tb/tb_axil_master_wrapper.sv
// Directed bench for axil_master_wrapper with a delay-configurable AXI4-Lite slave model.
// Stimulus and sampling happen on the falling edge, away from the DUT's rising edge.
module tb_axil_master_wrapper;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          wr_valid = 1'b0, rd_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, wr_done, rd_ready, rd_done;
  logic [1:0]    wr_error, rd_error;
  logic [DW-1:0] rd_data;

  logic [AW-1:0]   awaddr, araddr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            awvalid, wvalid, bready, arvalid, rready;
  logic            awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]      bresp = 2'd0, rresp = 2'd0;
  logic [DW-1:0]   rdata = '0;

  always #5 aclk = ~aclk;

  axil_master_wrapper #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .areset(areset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_error(wr_error),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_done(rd_done), .rd_error(rd_error),
    .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration, owned by the main stimulus process.
  int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'd0, rresp_cfg = 2'd0;

  // Handshake sampling on the rising edge; these see pre-edge values.
  logic          aw_hs_q = 0, w_hs_q = 0, b_hs_q = 0, ar_hs_q = 0, r_hs_q = 0;
  logic          wr_acc_q = 0, rd_acc_q = 0;
  logic [AW-1:0] aw_log [0:15];
  logic [DW-1:0] w_log  [0:15];
  logic [3:0]    ws_log [0:15];
  logic [AW-1:0] ar_cap = '0;
  int            aw_n = 0, w_n = 0, wd_n = 0, rd_n = 0;

  always @(posedge aclk) begin
    aw_hs_q  <= !areset && awvalid && awready;
    w_hs_q   <= !areset && wvalid && wready;
    b_hs_q   <= !areset && bvalid && bready;
    ar_hs_q  <= !areset && arvalid && arready;
    r_hs_q   <= !areset && rvalid && rready;
    wr_acc_q <= !areset && wr_valid && wr_ready;
    rd_acc_q <= !areset && rd_valid && rd_ready;
    if (!areset && awvalid && awready) begin
      aw_log[aw_n[3:0]] <= awaddr;
      aw_n <= aw_n + 1;
    end
    if (!areset && wvalid && wready) begin
      w_log[w_n[3:0]]  <= wdata;
      ws_log[w_n[3:0]] <= wstrb;
      w_n <= w_n + 1;
    end
    if (!areset && arvalid && arready) ar_cap <= araddr;
    if (wr_done) wd_n <= wd_n + 1;
    if (rd_done) rd_n <= rd_n + 1;
  end

  // Slave model: each ready/valid rises after its configured delay, drops after its handshake.
  initial begin
    int  aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    bit  got_aw = 0, got_w = 0, got_ar = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = '0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
      end else begin
        if (aw_hs_q) begin awready = 0; aw_c = 0; got_aw = 1; end
        else if (awvalid && !awready) begin
          if (aw_c >= aw_dly) awready = 1; else aw_c++;
        end
        if (w_hs_q) begin wready = 0; w_c = 0; got_w = 1; end
        else if (wvalid && !wready) begin
          if (w_c >= w_dly) wready = 1; else w_c++;
        end
        if (b_hs_q) begin bvalid = 0; b_c = 0; got_aw = 0; got_w = 0; end
        else if (got_aw && got_w && !bvalid) begin
          if (b_c >= b_dly) begin bvalid = 1; bresp = bresp_cfg; end else b_c++;
        end
        if (ar_hs_q) begin arready = 0; ar_c = 0; got_ar = 1; end
        else if (arvalid && !arready) begin
          if (ar_c >= ar_dly) arready = 1; else ar_c++;
        end
        if (r_hs_q) begin rvalid = 0; r_c = 0; got_ar = 0; end
        else if (got_ar && !rvalid) begin
          if (r_c >= r_dly) begin
            rvalid = 1; rresp = rresp_cfg; rdata = ar_cap + 32'h1000;
          end else r_c++;
        end
      end
    end
  end

  // Present a write at the current falling edge; return on the falling edge after acceptance.
  task automatic send_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    do begin @(negedge aclk); n++; end while (!wr_acc_q && n < 30);
    wr_valid = 0;
    check("wr_accept", wr_acc_q, 1);
  endtask

  task automatic send_read(input logic [AW-1:0] a);
    int n = 0;
    rd_valid = 1; rd_addr = a;
    do begin @(negedge aclk); n++; end while (!rd_acc_q && n < 30);
    rd_valid = 0;
    check("rd_accept", rd_acc_q, 1);
  endtask

  task automatic wait_wr_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge aclk);
      if (wr_done) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_rd_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge aclk);
      if (rd_done) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  logic [AW-1:0] b2b_addr [0:4];
  logic [DW-1:0] b2b_data [0:4];

  initial begin
    int wd0, rd0, n;
    b2b_addr[0] = 32'h0;   b2b_data[0] = 32'hA5A5_0001;
    b2b_addr[1] = 32'h4;   b2b_data[1] = 32'h1111_2222;
    b2b_addr[2] = 32'h8;   b2b_data[2] = 32'h3333_4444;
    b2b_addr[3] = 32'hC;   b2b_data[3] = 32'h5555_6666;
    b2b_addr[4] = 32'h100; b2b_data[4] = 32'h7777_8888;

    repeat (3) @(negedge aclk);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_ready", rd_ready, 1);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rd_data", rd_data, 0);
    areset = 0;
    @(negedge aclk);

    // Basic write
    send_write(32'h10, 32'hDEAD_BEEF);
    check("t1_awvalid_after_accept", awvalid, 1);
    check("t1_wvalid_after_accept", wvalid, 1);
    check("t1_wr_ready_busy", wr_ready, 0);
    wait_wr_done("t1_wr_done_seen");
    check("t1_wr_error", wr_error, 0);
    check("t1_wr_ready_in_done", wr_ready, 1);
    check("t1_awaddr", aw_log[0], 32'h10);
    check("t1_wdata", w_log[0], 32'hDEAD_BEEF);
    check("t1_wstrb", ws_log[0], 4'hF);
    @(negedge aclk);
    check("t1_done_single_pulse", wr_done, 0);
    check("t1_done_count", wd_n, 1);

    // Five back-to-back writes, wr_valid held high throughout
    wr_valid = 1; wr_addr = b2b_addr[0]; wr_data = b2b_data[0];
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin @(negedge aclk); n++; end while (!wr_acc_q && n < 30);
      check("t2_accept", wr_acc_q, 1);
      if (i < 4) begin wr_addr = b2b_addr[i+1]; wr_data = b2b_data[i+1]; end
      else wr_valid = 0;
    end
    repeat (10) @(negedge aclk);
    check("t2_done_count", wd_n, 6);
    check("t2_aw_count", aw_n, 6);
    check("t2_w_count", w_n, 6);
    check("t2_wr_error", wr_error, 0);
    for (int i = 0; i < 5; i++) begin
      check("t2_awaddr", aw_log[i+1], b2b_addr[i]);
      check("t2_wdata", w_log[i+1], b2b_data[i]);
    end

    // Read returning araddr + 0x1000
    send_read(32'h20);
    check("t3_arvalid_after_accept", arvalid, 1);
    wait_rd_done("t3_rd_done_seen");
    check("t3_rd_data", rd_data, 32'h1020);
    check("t3_rd_error", rd_error, 0);
    check("t3_rd_ready_in_done", rd_ready, 1);
    repeat (5) @(negedge aclk);
    check("t3_rd_data_hold", rd_data, 32'h1020);
    check("t3_rd_done_low", rd_done, 0);

    // wready three cycles ahead of awready
    aw_dly = 3; w_dly = 0;
    send_write(32'h40, 32'h1234_5678);
    n = 0;
    do begin @(negedge aclk); n++; end while (!w_hs_q && n < 30);
    check("t4_w_hs_seen", w_hs_q, 1);
    check("t4_wvalid_dropped", wvalid, 0);
    check("t4_awvalid_held", awvalid, 1);
    check("t4_bready_early", bready, 0);
    n = 0;
    do begin @(negedge aclk); n++; end while (!aw_hs_q && n < 30);
    check("t4_aw_hs_seen", aw_hs_q, 1);
    check("t4_aw_w_gap", n, 3);
    check("t4_awvalid_dropped", awvalid, 0);
    check("t4_bready_after_both", bready, 1);
    wait_wr_done("t4_wr_done_seen");
    check("t4_awaddr", aw_log[6], 32'h40);
    check("t4_wdata", w_log[6], 32'h1234_5678);
    aw_dly = 0;

    // Error responses pass through
    bresp_cfg = 2'd2; rresp_cfg = 2'd3;
    send_write(32'h50, 32'hCAFE_F00D);
    wait_wr_done("t5_wr_done_seen");
    check("t5_wr_error_slverr", wr_error, 2'd2);
    send_read(32'h60);
    wait_rd_done("t5_rd_done_seen");
    check("t5_rd_error_decerr", rd_error, 2'd3);
    check("t5_rd_data", rd_data, 32'h1060);
    bresp_cfg = 2'd0; rresp_cfg = 2'd0;
    @(negedge aclk);

    // Concurrent write and read accepted on the same edge
    wd0 = wd_n; rd0 = rd_n;
    wr_valid = 1; wr_addr = 32'h80; wr_data = 32'h0BAD_F00D;
    rd_valid = 1; rd_addr = 32'h70;
    @(negedge aclk);
    wr_valid = 0; rd_valid = 0;
    check("t6_wr_acc_same_edge", wr_acc_q, 1);
    check("t6_rd_acc_same_edge", rd_acc_q, 1);
    n = 0;
    while ((wd_n < wd0 + 1 || rd_n < rd0 + 1) && n < 40) begin @(negedge aclk); n++; end
    repeat (3) @(negedge aclk);
    check("t6_wr_done_count", wd_n, wd0 + 1);
    check("t6_rd_done_count", rd_n, rd0 + 1);
    check("t6_rd_data", rd_data, 32'h1070);
    check("t6_wr_error", wr_error, 0);

    // Abort both in flight with reset
    aw_dly = 8; w_dly = 8; ar_dly = 8;
    wd0 = wd_n; rd0 = rd_n;
    wr_valid = 1; wr_addr = 32'h90; wr_data = 32'h5A5A_5A5A;
    rd_valid = 1; rd_addr = 32'hA0;
    @(negedge aclk);
    wr_valid = 0; rd_valid = 0;
    @(negedge aclk);
    check("t6_awvalid_inflight", awvalid, 1);
    check("t6_arvalid_inflight", arvalid, 1);
    areset = 1;
    @(negedge aclk);
    check("t6_rst_wr_ready", wr_ready, 1);
    check("t6_rst_rd_ready", rd_ready, 1);
    check("t6_rst_awvalid", awvalid, 0);
    check("t6_rst_wvalid", wvalid, 0);
    check("t6_rst_bready", bready, 0);
    check("t6_rst_arvalid", arvalid, 0);
    check("t6_rst_rready", rready, 0);
    check("t6_rst_wr_error", wr_error, 0);
    check("t6_rst_rd_error", rd_error, 0);
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_awaddr", awaddr, 0);
    check("t6_rst_wdata", wdata, 0);
    check("t6_rst_araddr", araddr, 0);
    @(negedge aclk);
    areset = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    repeat (15) @(negedge aclk);
    check("t6_no_wr_done_after_abort", wd_n, wd0);
    check("t6_no_rd_done_after_abort", rd_n, rd0);
    check("t6_idle_wr_ready", wr_ready, 1);
    check("t6_idle_awvalid", awvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
